// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state encoding, word/round sizes and the
// bitwise helper functions used by the round and schedule logic.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int SHA_ROUNDS = 64;
    localparam int WIN_WORDS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL
    } state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                             input logic [WORD_W-1:0] f,
                                             input logic [WORD_W-1:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                              input logic [WORD_W-1:0] b,
                                              input logic [WORD_W-1:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_window.sv
// 16-word message schedule window; slot 0 always holds W_t and each shift
// appends the next expanded word W_{t+16} at the tail.
module sha256_msg_window
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [511:0]        blk_data_i,
    output logic [WORD_W-1:0]   w_o
);

    logic [WORD_W-1:0] win_q [WIN_WORDS];
    logic [WORD_W-1:0] win_d [WIN_WORDS];
    logic [WORD_W-1:0] nextWord;

    assign nextWord = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

    always_comb begin
        for (int i = 0; i < WIN_WORDS; i++) begin
            win_d[i] = win_q[i];
        end
        if (load_i) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                win_d[i] = blk_data_i[511 - 32*i -: 32];
            end
        end else if (shift_i) begin
            for (int i = 0; i < WIN_WORDS - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN_WORDS-1] = nextWord;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign w_o = win_q[0];

endmodule

// File: rtl/sha256_compress.sv
// Sequential SHA-256 compression engine: one round per clock, chaining value
// kept internally so multi-block messages need only blk_first on block 0.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA_ROUNDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [255:0]    initialHashValues,
    input  logic [2047:0]   constantValues,
    input  logic            blk_valid,
    output logic            blk_ready,
    input  logic [511:0]    blk_data,
    input  logic            blk_first,
    output logic [255:0]    digest,
    output logic            digest_valid
);

    localparam int CNT_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int K_WORDS = 2048 / WORD_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    roundCnt_q, roundCnt_d;
    logic                idleState, handshake, shiftWin;
    logic [WORD_W-1:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [255:0]        chain_q, digest_q, initChain;
    logic                digestValid_q;
    logic [WORD_W-1:0]   wT, kWord, t1, t2;
    logic [WORD_W-1:0]   kTab [K_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            roundCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            roundCnt_q <= roundCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        roundCnt_d = roundCnt_q;
        idleState  = 1'b0;
        shiftWin   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idleState = 1'b1;
                if (blk_valid) begin
                    roundCnt_d = '0;
                    state_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                shiftWin   = 1'b1;
                roundCnt_d = roundCnt_q + CNT_W'(1);
                if (roundCnt_q == CNT_W'(ROUNDS - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is masked by reset so no block can slip in during the reset cycle.
    assign blk_ready = idleState && !rst;
    assign handshake = blk_valid && blk_ready;
    assign initChain = blk_first ? initialHashValues : digest_q;

    sha256_msg_window u_window (
        .clk        (clk),
        .load_i     (handshake),
        .shift_i    (shiftWin),
        .blk_data_i (blk_data),
        .w_o        (wT)
    );

    always_comb begin
        for (int i = 0; i < K_WORDS; i++) begin
            kTab[i] = constantValues[2047 - 32*i -: 32];
        end
    end

    assign kWord = kTab[roundCnt_q];
    assign t1    = h_q + bsig1(e_q) + ch(e_q, f_q, g_q) + kWord + wT;
    assign t2    = bsig0(a_q) + maj(a_q, b_q, c_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            digest_q      <= '0;
            digestValid_q <= 1'b0;
        end else begin
            digestValid_q <= (state_q == ST_FINAL);
            if (handshake) begin
                chain_q <= initChain;
                {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= initChain;
            end else if (state_q == ST_ROUND) begin
                h_q <= g_q;
                g_q <= f_q;
                f_q <= e_q;
                e_q <= d_q + t1;
                d_q <= c_q;
                c_q <= b_q;
                b_q <= a_q;
                a_q <= t1 + t2;
            end
            if (state_q == ST_FINAL) begin
                digest_q <= {chain_q[255:224] + a_q, chain_q[223:192] + b_q,
                             chain_q[191:160] + c_q, chain_q[159:128] + d_q,
                             chain_q[127:96]  + e_q, chain_q[95:64]   + f_q,
                             chain_q[63:32]   + g_q, chain_q[31:0]    + h_q};
            end
        end
    end

    assign digest       = digest_q;
    assign digest_valid = digestValid_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: standard vectors, handshake and
// reset corner cases, then random blocks against a full-schedule reference.
module tb_sha256_compress;

    localparam logic [255:0] IV_STD = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h00000000}}};
    localparam logic [511:0] BLK_L1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_L2 = {{15{32'h00000000}}, 32'h000001c0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    bit [31:0] kTab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [255:0]   ivBus = '0;
    logic [2047:0]  kBus = '0;
    logic           blk_valid = 1'b0;
    logic           blk_ready;
    logic [511:0]   blk_data = '0;
    logic           blk_first = 1'b0;
    logic [255:0]   digest;
    logic           digest_valid;

    int checksTotal  = 0;
    int checksPassed = 0;

    sha256_compress dut (
        .clk               (clk),
        .rst               (rst),
        .initialHashValues (ivBus),
        .constantValues    (kBus),
        .blk_valid         (blk_valid),
        .blk_ready         (blk_ready),
        .blk_data          (blk_data),
        .blk_first         (blk_first),
        .digest            (digest),
        .digest_valid      (digest_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit [31:0] rot(input bit [31:0] x, input int n);
        bit [63:0] dbl;
        dbl = {x, x} >> n;
        return dbl[31:0];
    endfunction

    // Whole-block reference: full 64-word schedule, then the 64 rounds.
    function automatic logic [255:0] refCompress(input logic [255:0] chainIn, input logic [511:0] blockIn);
        bit [31:0] w [64];
        bit [31:0] v [8];
        bit [31:0] hIn [8];
        bit [31:0] s0, s1, t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blockIn[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rot(w[i-15], 7) ^ rot(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rot(w[i-2], 17) ^ rot(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) begin
            hIn[i] = chainIn[255 - 32*i -: 32];
            v[i]   = hIn[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rot(v[4], 6) ^ rot(v[4], 11) ^ rot(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kTab[t] + w[t];
            t2 = (rot(v[0], 2) ^ rot(v[0], 13) ^ rot(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hIn[i] + v[i];
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checksTotal++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end else begin
            checksPassed++;
        end
    endtask

    // Submits one block and waits for its digest; optionally toggles
    // blk_valid with junk data while the engine is busy.
    task automatic applyStimulus(input logic [511:0] data, input logic first, input bit toggleBusy,
                                 output logic [255:0] dig, output int lat,
                                 output int extraHs, output int readyBusy);
        int n;
        logic rdy;
        n = 0; extraHs = 0; readyBusy = 0;
        @(negedge clk);
        while (!blk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("readyTimeout", {255'd0, blk_ready}, 256'd1);
        blk_data  = data;
        blk_first = first;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        lat = 1;
        while (!digest_valid && lat < 200) begin
            @(negedge clk);
            if (toggleBusy) begin
                blk_valid = (lat < 60) && lat[0];
                for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = $urandom();
            end
            rdy = blk_ready;
            if (rdy) readyBusy++;
            @(posedge clk); #1;
            if (rdy && blk_valid) extraHs++;
            lat++;
        end
        blk_valid = 1'b0;
        dig = digest;
    endtask

    initial begin
        logic [255:0] dig, expDig, refChain;
        int lat, extraHs, readyBusy, cyc, hs, t0, readyInRound, pulses;
        logic rdy, first;
        int pulseCyc[$];
        logic [255:0] pulseDig[$];

        for (int i = 0; i < 64; i++) kBus[2047 - 32*i -: 32] = kTab[i];
        ivBus = IV_STD;

        @(posedge clk); @(posedge clk); #1;
        checkOutput("resetDigest", digest, 256'd0);
        checkOutput("resetValid", {255'd0, digest_valid}, 256'd0);
        checkOutput("readyInReset", {255'd0, blk_ready}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", {255'd0, blk_ready}, 256'd1);

        applyStimulus(BLK_ABC, 1'b1, 1'b0, dig, lat, extraHs, readyBusy);
        checkOutput("abcDigest", dig, DIG_ABC);
        checkOutput("abcLatency", 256'(lat), 256'd66);
        checkOutput("abcReadyBusy", 256'(readyBusy), 256'd0);

        applyStimulus(BLK_EMPTY, 1'b1, 1'b0, dig, lat, extraHs, readyBusy);
        checkOutput("emptyDigest", dig, DIG_EMPTY);
        checkOutput("emptyLatency", 256'(lat), 256'd66);

        applyStimulus(BLK_L1, 1'b1, 1'b0, dig, lat, extraHs, readyBusy);
        applyStimulus(BLK_L2, 1'b0, 1'b0, dig, lat, extraHs, readyBusy);
        checkOutput("twoBlockDigest", dig, DIG_448);

        // Back-to-back with blk_valid held high throughout.
        @(negedge clk);
        blk_data = BLK_ABC; blk_first = 1'b1; blk_valid = 1'b1;
        cyc = 0; hs = 0; t0 = 0; readyInRound = 0;
        while (pulseCyc.size() < 2 && cyc < 400) begin
            rdy = blk_ready;
            if (hs > 0 && rdy && !digest_valid) readyInRound++;
            @(posedge clk); #1;
            cyc++;
            if (rdy && blk_valid) begin
                hs++;
                if (hs == 1) begin
                    t0 = cyc;
                    blk_data = BLK_EMPTY;
                end else begin
                    blk_valid = 1'b0;
                end
            end
            if (digest_valid) begin
                pulseCyc.push_back(cyc);
                pulseDig.push_back(digest);
            end
            @(negedge clk);
        end
        blk_valid = 1'b0;
        checkOutput("b2bPulseCount", 256'(pulseCyc.size()), 256'd2);
        checkOutput("b2bHandshakes", 256'(hs), 256'd2);
        checkOutput("b2bReadyInRound", 256'(readyInRound), 256'd0);
        if (pulseCyc.size() == 2) begin
            checkOutput("b2bFirstLatency", 256'(pulseCyc[0] - t0 + 1), 256'd66);
            checkOutput("b2bSpacing", 256'(pulseCyc[1] - pulseCyc[0]), 256'd66);
            checkOutput("b2bDigestAbc", pulseDig[0], DIG_ABC);
            checkOutput("b2bDigestEmpty", pulseDig[1], DIG_EMPTY);
        end

        // Reset in the middle of a block.
        @(negedge clk);
        blk_data = BLK_ABC; blk_first = 1'b1; blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midResetDigest", digest, 256'd0);
        checkOutput("midResetValid", {255'd0, digest_valid}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midResetReady", {255'd0, blk_ready}, 256'd1);
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (digest_valid) pulses++;
        end
        checkOutput("midResetNoPulse", 256'(pulses), 256'd0);
        applyStimulus(BLK_ABC, 1'b1, 1'b0, dig, lat, extraHs, readyBusy);
        checkOutput("resubmitDigest", dig, DIG_ABC);

        applyStimulus(BLK_ABC, 1'b1, 1'b1, dig, lat, extraHs, readyBusy);
        checkOutput("toggleExtraHs", 256'(extraHs), 256'd0);
        checkOutput("toggleDigest", dig, DIG_ABC);
        checkOutput("toggleLatency", 256'(lat), 256'd66);

        // Random blocks, random chaining, random IV on first blocks.
        refChain = '0;
        for (int k = 0; k < 10; k++) begin
            logic [511:0] data;
            first = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (first) begin
                for (int i = 0; i < 8; i++) ivBus[255 - 32*i -: 32] = $urandom();
            end
            for (int i = 0; i < 16; i++) data[511 - 32*i -: 32] = $urandom();
            expDig = refCompress(first ? ivBus : refChain, data);
            applyStimulus(data, first, 1'b0, dig, lat, extraHs, readyBusy);
            checkOutput($sformatf("randDigest%0d", k), dig, expDig);
            checkOutput($sformatf("randLatency%0d", k), 256'(lat), 256'd66);
            refChain = expDig;
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
